// File: rtl/dvi_video_timing_if.sv
// Pixel request / video output bundle between the raster timing
// generator (master) and the pixel source plus DVI transmitter (slave).
interface dvi_video_timing_if;
    logic        req_valid;
    logic [10:0] req_x;
    logic [10:0] req_y;
    logic        frame_start;
    logic [23:0] pix_in;
    logic [23:0] rgb_out;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;

    modport master (
        output req_valid, req_x, req_y, frame_start,
        output rgb_out, de_out, hsync_out, vsync_out,
        input  pix_in
    );

    modport slave (
        input  req_valid, req_x, req_y, frame_start,
        input  rgb_out, de_out, hsync_out, vsync_out,
        output pix_in
    );
endinterface

// File: rtl/dvi_video_timing.sv
// Raster timing generator and pixel aligner. Waits for the transmitter to
// be configured, then runs whole frames; requests pixels from a fixed
// latency source and re-aligns DE/syncs with the returned RGB data.
module dvi_video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init_done,
    output logic               running,
    dvi_video_timing_if.master vif
);
    localparam int STAGES = PIX_LAT + 1;

    localparam logic [10:0] H_TOTAL = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] V_TOTAL = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } tap_t;

    state_t              state, state_nxt;
    logic [10:0]         h_cnt, v_cnt, h_nxt, v_nxt;
    logic                h_end, v_end;
    tap_t                raw;
    tap_t [STAGES:1]     vld_pipe;
    logic [23:0]         rgb_q;

    assign h_end = (h_cnt == H_TOTAL - 11'd1);
    assign v_end = (v_cnt == V_TOTAL - 11'd1);

    // State and raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Next state: leave RUN only at the last clock of a frame, so a frame
    // is never cut short; counters sit at zero outside RUN.
    always_comb begin
        state_nxt = state;
        h_nxt     = '0;
        v_nxt     = '0;
        case (state)
            IDLE: begin
                if (init_done) state_nxt = RUN;
            end
            RUN: begin
                h_nxt = h_end ? '0 : h_cnt + 11'd1;
                v_nxt = h_end ? (v_end ? '0 : v_cnt + 11'd1) : v_cnt;
                if (h_end && v_end && !init_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raw active/sync flags evaluated at the counter position
    always_comb begin
        raw = '0;
        if (state == RUN) begin
            raw.act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
            raw.hs  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
            raw.vs  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        end
    end

    assign running         = (state == RUN);
    assign vif.req_valid   = raw.act;
    assign vif.req_x       = raw.act ? h_cnt : '0;
    assign vif.req_y       = raw.act ? v_cnt : '0;
    assign vif.frame_start = (state == RUN) && (h_cnt == '0) && (v_cnt == '0);

    // Delay line matching the pixel source latency plus the RGB register;
    // it keeps shifting in IDLE so the tail of the last frame drains out.
    always_ff @(posedge clk) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:1], raw};
    end

    // Capture the source pixel when the matching request arrives back
    always_ff @(posedge clk) begin
        if (reset)                     rgb_q <= '0;
        else if (vld_pipe[PIX_LAT].act) rgb_q <= vif.pix_in;
        else                           rgb_q <= '0;
    end

    assign vif.rgb_out   = rgb_q;
    assign vif.de_out    = vld_pipe[STAGES].act;
    assign vif.hsync_out = vld_pipe[STAGES].hs ? HS_POL : ~HS_POL;
    assign vif.vsync_out = vld_pipe[STAGES].vs ? VS_POL : ~VS_POL;
endmodule

// File: tb/tb_dvi_video_timing.sv
// Randomized bench for dvi_video_timing on a shrunken raster. The reference
// tracks a linear position within the frame plus a delay history.
module tb_dvi_video_timing;
    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 4;
    localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int PIX_LAT = 2;
    localparam int STAGES = PIX_LAT + 1;
    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b0;

    logic clk = 1'b0;
    logic reset;
    logic init_done;
    logic running;

    dvi_video_timing_if vif ();

    dvi_video_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .PIX_LAT(PIX_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .init_done(init_done),
        .running(running),
        .vif(vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit run, act, hs, vs, fs;
        int x, y;
    } raw_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   m_run = 0;
    int   m_pos = 0;
    raw_t dq [STAGES+1];

    // Pixel source: answers each request PIX_LAT clocks later, garbage otherwise
    bit        src_v [PIX_LAT+1];
    bit [10:0] src_x [PIX_LAT+1];
    bit [10:0] src_y [PIX_LAT+1];

    function automatic logic [23:0] pat(int x, int y);
        logic [7:0] xb, yb;
        xb = 8'(x);
        yb = 8'(y);
        return {yb, xb, 8'h5A};
    endfunction

    always @(negedge clk) begin
        for (int k = PIX_LAT; k > 0; k--) begin
            src_v[k] = src_v[k-1];
            src_x[k] = src_x[k-1];
            src_y[k] = src_y[k-1];
        end
        src_v[0] = vif.req_valid;
        src_x[0] = vif.req_x;
        src_y[0] = vif.req_y;
        vif.pix_in = src_v[PIX_LAT] ? pat(int'(src_x[PIX_LAT]), int'(src_y[PIX_LAT]))
                                    : 24'($urandom);
    end

    function automatic raw_t mk(bit run, int pos);
        raw_t r;
        r.run = run;
        r.x   = pos % HT;
        r.y   = pos / HT;
        r.act = run && r.x < HA && r.y < VA;
        r.hs  = run && r.x >= HA + HFP && r.x < HA + HFP + HSY;
        r.vs  = run && r.y >= VA + VFP && r.y < VA + VFP + VSY;
        r.fs  = run && pos == 0;
        return r;
    endfunction

    task automatic chk(string tag, int got, int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(bit r, bit i);
        if (r) begin
            m_run = 0;
            m_pos = 0;
            for (int k = 0; k <= STAGES; k++) dq[k] = mk(0, 0);
        end else begin
            if (!m_run) begin
                if (i) begin m_run = 1; m_pos = 0; end
            end else if (m_pos == FRAME - 1 && !i) begin
                m_run = 0;
                m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
            for (int k = STAGES; k > 0; k--) dq[k] = dq[k-1];
            dq[0] = mk(m_run, m_pos);
        end
    endtask

    task automatic step(bit r, bit i);
        raw_t c, o;
        reset     = r;
        init_done = i;
        @(posedge clk);
        cyc++;
        model_edge(r, i);
        @(negedge clk);
        c = dq[0];
        o = dq[STAGES];
        chk("running",     int'(running),         int'(c.run));
        chk("req_valid",   int'(vif.req_valid),   int'(c.act));
        chk("req_x",       int'(vif.req_x),       c.act ? c.x : 0);
        chk("req_y",       int'(vif.req_y),       c.act ? c.y : 0);
        chk("frame_start", int'(vif.frame_start), int'(c.fs));
        chk("de_out",      int'(vif.de_out),      int'(o.act));
        chk("rgb_out",     int'(vif.rgb_out),     o.act ? int'(pat(o.x, o.y)) : 0);
        chk("hsync_out",   int'(vif.hsync_out),   int'(o.hs ? HS_POL : !HS_POL));
        chk("vsync_out",   int'(vif.vsync_out),   int'(o.vs ? VS_POL : !VS_POL));
    endtask

    // Run with init_done high until the model reaches the given line
    task automatic run_to_line(int line);
        int n = 0;
        while (!(m_run && m_pos / HT == line) && n < 4 * FRAME) begin
            step(0, 1);
            n++;
        end
        chk("wait_line", int'(m_run && m_pos / HT == line), 1);
    endtask

    initial begin
        reset     = 1'b1;
        init_done = 1'b1;
        for (int k = 0; k <= STAGES; k++) dq[k] = mk(0, 0);

        for (int k = 0; k < 10; k++)  step(1, 1);
        for (int k = 0; k < 100; k++) step(0, 0);
        for (int k = 0; k < 3 * FRAME; k++) step(0, 1);

        // drop init_done mid-frame: frame completes, then drains and idles
        run_to_line(3);
        for (int k = 0; k < FRAME + 20; k++) step(0, 0);
        for (int k = 0; k < FRAME / 2; k++) step(0, 1);

        // brief drop that recovers before frame end: no gap
        run_to_line(2);
        for (int k = 0; k < 30; k++) step(0, 0);
        for (int k = 0; k < FRAME; k++) step(0, 1);

        // reset mid-frame aborts without draining
        run_to_line(4);
        step(1, 1);
        for (int k = 0; k < 10; k++) step(0, 0);

        // random init_done levels with occasional resets
        for (int b = 0; b < 30; b++) begin
            bit i;
            int len;
            i   = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 400);
            for (int k = 0; k < len; k++) step($urandom_range(0, 999) == 0, i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
